// File: rtl/washer_pkg.sv
// Shared types for the washing-machine controller: program state encoding
// and the set of states that run with the door locked.
package washer_pkg;

    typedef enum logic [2:0] {
        CHECK_DOOR    = 3'd0,
        FILL_WATER    = 3'd1,
        ADD_DETERGENT = 3'd2,
        CYCLE         = 3'd3,
        DRAIN_WATER   = 3'd4,
        SPIN          = 3'd5,
        DONE          = 3'd6
    } state_t;

    // Active program states: door must stay shut, otherwise the machine pauses.
    function automatic logic in_program(input state_t s);
        return (s == FILL_WATER) || (s == ADD_DETERGENT) || (s == CYCLE) ||
               (s == DRAIN_WATER) || (s == SPIN);
    endfunction

endpackage

// File: rtl/automatic_washing_machine.sv
// Moore wash-program sequencer: one state step per clock when the awaited input is high.
// Actuators decode from the registered state; an open door pauses the program and cuts actuators.
module automatic_washing_machine
    import washer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic door_close,
    input  logic start,
    input  logic filled,
    input  logic detergent_added,
    input  logic cycle_timeout,
    input  logic drained,
    input  logic spin_timeout,
    output logic door_lock,
    output logic motor_on,
    output logic fill_value_on,
    output logic drain_value_on,
    output logic done,
    output logic soap_wash,
    output logic water_wash
);

    state_t state_q, state_d;
    logic   soap_wash_q, soap_wash_d;
    logic   water_wash_q, water_wash_d;
    logic   door_hold;

    assign door_hold = in_program(state_q) && !door_close;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= CHECK_DOOR;
            soap_wash_q  <= 1'b0;
            water_wash_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            soap_wash_q  <= soap_wash_d;
            water_wash_q <= water_wash_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!door_hold) begin
            case (state_q)
                CHECK_DOOR: begin
                    if (start && door_close) state_d = FILL_WATER;
                end
                FILL_WATER: begin
                    // Second fill of the program is the rinse, so detergent is skipped.
                    if (filled) state_d = soap_wash_q ? CYCLE : ADD_DETERGENT;
                end
                ADD_DETERGENT: begin
                    if (detergent_added) state_d = CYCLE;
                end
                CYCLE: begin
                    if (cycle_timeout) state_d = DRAIN_WATER;
                end
                DRAIN_WATER: begin
                    if (drained) state_d = water_wash_q ? SPIN : FILL_WATER;
                end
                SPIN: begin
                    if (spin_timeout) state_d = DONE;
                end
                DONE:    state_d = CHECK_DOOR;
                default: state_d = CHECK_DOOR;
            endcase
        end
    end

    always_comb begin
        soap_wash_d  = soap_wash_q;
        water_wash_d = water_wash_q;
        if (!door_hold) begin
            case (state_q)
                ADD_DETERGENT: begin
                    if (detergent_added) soap_wash_d = 1'b1;
                end
                DRAIN_WATER: begin
                    if (drained && !water_wash_q) water_wash_d = 1'b1;
                end
                DONE: begin
                    soap_wash_d  = 1'b0;
                    water_wash_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        door_lock      = 1'b0;
        motor_on       = 1'b0;
        fill_value_on  = 1'b0;
        drain_value_on = 1'b0;
        done           = 1'b0;
        case (state_q)
            FILL_WATER: begin
                door_lock     = 1'b1;
                fill_value_on = 1'b1;
            end
            ADD_DETERGENT: door_lock = 1'b1;
            CYCLE: begin
                door_lock = 1'b1;
                motor_on  = 1'b1;
            end
            DRAIN_WATER: begin
                door_lock      = 1'b1;
                drain_value_on = 1'b1;
            end
            SPIN: begin
                door_lock      = 1'b1;
                motor_on       = 1'b1;
                drain_value_on = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
        if (door_hold) begin
            motor_on       = 1'b0;
            fill_value_on  = 1'b0;
            drain_value_on = 1'b0;
        end
    end

    assign soap_wash  = soap_wash_q;
    assign water_wash = water_wash_q;

endmodule

// File: tb/tb_automatic_washing_machine.sv
// Self-checking bench: directed scenarios plus random input streams against a program-step model.
module tb_automatic_washing_machine;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic door_close = 1'b0, start = 1'b0, filled = 1'b0, detergent_added = 1'b0;
    logic cycle_timeout = 1'b0, drained = 1'b0, spin_timeout = 1'b0;
    logic door_lock, motor_on, fill_value_on, drain_value_on, done, soap_wash, water_wash;

    int tests = 0;
    int fails = 0;

    // Model: position in the fixed program.
    // 0 idle, 1 fill, 2 detergent, 3 wash, 4 drain, 5 rinse fill, 6 rinse, 7 drain, 8 spin, 9 done
    int step = 0;

    automatic_washing_machine dut (
        .clk(clk), .reset(reset), .door_close(door_close), .start(start),
        .filled(filled), .detergent_added(detergent_added),
        .cycle_timeout(cycle_timeout), .drained(drained), .spin_timeout(spin_timeout),
        .door_lock(door_lock), .motor_on(motor_on), .fill_value_on(fill_value_on),
        .drain_value_on(drain_value_on), .done(done), .soap_wash(soap_wash),
        .water_wash(water_wash)
    );

    always #5 clk = ~clk;

    function automatic logic awaited_input(input int s);
        case (s)
            1, 5:    return filled;
            2:       return detergent_added;
            3, 6:    return cycle_timeout;
            4, 7:    return drained;
            8:       return spin_timeout;
            default: return 1'b0;
        endcase
    endfunction

    // {door_lock, motor_on, fill, drain, done, soap_wash, water_wash}
    function automatic logic [6:0] expected();
        logic [4:0] act;
        case (step)
            1, 5:    act = 5'b10100;
            2:       act = 5'b10000;
            3, 6:    act = 5'b11000;
            4, 7:    act = 5'b10010;
            8:       act = 5'b11010;
            9:       act = 5'b00001;
            default: act = 5'b00000;
        endcase
        if (step >= 1 && step <= 8 && !door_close) act = act & 5'b10000;
        return {act, logic'(step >= 3), logic'(step >= 5)};
    endfunction

    function automatic logic [6:0] observed();
        return {door_lock, motor_on, fill_value_on, drain_value_on, done, soap_wash, water_wash};
    endfunction

    task automatic advance();
        if (step == 0) begin
            if (start && door_close) step = 1;
        end else if (step == 9) begin
            step = 0;
        end else if (door_close && awaited_input(step)) begin
            step = step + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) advance();
        #1;
    endtask

    task automatic set_in(input logic s, input logic d, input logic f, input logic det,
                          input logic c, input logic dr, input logic sp);
        start = s; door_close = d; filled = f; detergent_added = det;
        cycle_timeout = c; drained = dr; spin_timeout = sp;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        step = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        step = 0;
        tests++;
        if (observed() !== 7'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b want %b", observed(), 7'b0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (observed() !== 7'b0) begin
                fails++;
                $display("FAIL idle_after_reset[%0d]: got %b want %b", i, observed(), 7'b0);
            end
        end
    endtask

    task automatic test_all_high();
        int count;
        do_reset();
        set_in(1, 1, 1, 1, 1, 1, 1);
        count = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            count++;
            tests++;
            if (observed() !== expected()) begin
                fails++;
                $display("FAIL all_high_cycle%0d: got %b want %b", count, observed(), expected());
            end
            if (done === 1'b1) break;
        end
        tests++;
        if (count != 9 || done !== 1'b1) begin
            fails++;
            $display("FAIL all_high_latency: got %0d cycles (done=%b) want 9", count, done);
        end
        start = 1'b0;
        tick();
        tests++;
        if (observed() !== 7'b0) begin
            fails++;
            $display("FAIL after_done_idle: got %b want %b", observed(), 7'b0);
        end
    endtask

    task automatic test_door_open_idle();
        do_reset();
        set_in(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (observed() !== 7'b0 || door_lock !== 1'b0) begin
                fails++;
                $display("FAIL door_open_idle[%0d]: got %b want %b", i, observed(), 7'b0);
            end
        end
        door_close = 1'b1;
        tick();
        tests++;
        if (fill_value_on !== 1'b1 || observed() !== expected()) begin
            fails++;
            $display("FAIL fill_after_close: got %b want %b", observed(), expected());
        end
    endtask

    task automatic test_nominal();
        logic [6:0] want [0:7];
        want[0] = 7'b1010000;
        want[1] = 7'b1000000;
        want[2] = 7'b1100010;
        want[3] = 7'b1001010;
        want[4] = 7'b1010011;
        want[5] = 7'b1100011;
        want[6] = 7'b1001011;
        want[7] = 7'b1101011;
        do_reset();
        set_in(1, 1, 0, 0, 0, 0, 0);
        tick();
        start = 1'b0;
        tick();
        tests++;
        if (observed() !== want[0]) begin
            fails++;
            $display("FAIL nominal_fill: got %b want %b", observed(), want[0]);
        end
        for (int ph = 1; ph < 9; ph++) begin
            case (ph)
                1, 5: filled = 1'b1;
                2:    detergent_added = 1'b1;
                3, 6: cycle_timeout = 1'b1;
                4, 7: drained = 1'b1;
                default: spin_timeout = 1'b1;
            endcase
            tick();
            set_in(0, 1, 0, 0, 0, 0, 0);
            #1;
            tick();
            tests++;
            if (ph < 8 && observed() !== want[ph]) begin
                fails++;
                $display("FAIL nominal_phase%0d: got %b want %b", ph, observed(), want[ph]);
            end else if (ph == 8 && (done !== 1'b0 || observed() !== 7'b0)) begin
                fails++;
                $display("FAIL nominal_done_width: got %b want %b", observed(), 7'b0);
            end
        end
    endtask

    task automatic test_done_pulse();
        do_reset();
        set_in(1, 1, 1, 1, 1, 1, 1);
        for (int i = 0; i < 8; i++) tick();
        start = 1'b0;
        tick();
        tests++;
        if (done !== 1'b1 || door_lock !== 1'b0) begin
            fails++;
            $display("FAIL done_state: got done=%b lock=%b want done=1 lock=0", done, door_lock);
        end
    endtask

    task automatic test_interlock();
        do_reset();
        set_in(1, 1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        set_in(0, 0, 0, 0, 1, 1, 1);
        #1;
        tests++;
        if (motor_on !== 1'b0 || door_lock !== 1'b1) begin
            fails++;
            $display("FAIL interlock_open: got motor=%b lock=%b want motor=0 lock=1", motor_on, door_lock);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (observed() !== 7'b1000010) begin
                fails++;
                $display("FAIL interlock_hold[%0d]: got %b want %b", i, observed(), 7'b1000010);
            end
        end
        set_in(0, 1, 0, 0, 0, 0, 0);
        #1;
        tests++;
        if (motor_on !== 1'b1) begin
            fails++;
            $display("FAIL interlock_reclose: got motor=%b want 1", motor_on);
        end
        cycle_timeout = 1'b1;
        tick();
        tests++;
        if (observed() !== 7'b1001010) begin
            fails++;
            $display("FAIL interlock_resume: got %b want %b", observed(), 7'b1001010);
        end
    endtask

    task automatic test_reset_mid_spin();
        do_reset();
        set_in(1, 1, 1, 1, 1, 1, 0);
        for (int i = 0; i < 8; i++) tick();
        tests++;
        if (observed() !== 7'b1101011) begin
            fails++;
            $display("FAIL reach_spin: got %b want %b", observed(), 7'b1101011);
        end
        reset = 1'b0;
        #1;
        step = 0;
        tests++;
        if (observed() !== 7'b0) begin
            fails++;
            $display("FAIL async_reset_spin: got %b want %b", observed(), 7'b0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        int last, cyc;
        set_in(1, 1, 1, 1, 1, 1, 1);
        last = -1;
        cyc = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            cyc++;
            tests++;
            if (observed() !== expected()) begin
                fails++;
                $display("FAIL b2b_cycle%0d: got %b want %b", cyc, observed(), expected());
            end
            if (done === 1'b1) begin
                if (last >= 0) break;
                last = cyc;
            end
        end
        tests++;
        if (last != 9 || cyc != 19 || done !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second_done: got first=%0d second=%0d want 9 and 19", last, cyc);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            set_in(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 6) != 0),
                   logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 2) == 0),
                   logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 2) == 0),
                   logic'($urandom_range(0, 2) == 0));
            #1;
            tests++;
            if (observed() !== expected()) begin
                fails++;
                $display("FAIL random_cycle%0d: got %b want %b (step %0d)", i, observed(), expected(), step);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_all_high();
        test_door_open_idle();
        test_nominal();
        test_done_pulse();
        test_interlock();
        test_reset_mid_spin();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
